// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
// Optional grant timeout is enabled by defining ARB_GRANT_TIMEOUT_EN.
package arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    localparam int MAX_N = 64;

    function automatic int idw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cw_of(input int cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

    function automatic logic [31:0] oh2idx(input logic [MAX_N-1:0] oh);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = idx | 32'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping.
// Purely combinational; the arbiter registers its result.
module rr_prio_pick
    import arb_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = idw_of(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   pick_oh,
    output logic [IDW-1:0] pick_id,
    output logic           pick_vld
);

    logic [N-1:0] w_rot;
    logic [N-1:0] w_first;
    logic         w_found;

    // Rotate so ptr lands at bit 0, take lowest one, rotate back.
    always_comb begin
        w_rot   = '0;
        w_first = '0;
        w_found = 1'b0;
        pick_oh = '0;
        for (int i = 0; i < N; i++) begin
            w_rot[i] = req[(i + int'(ptr)) % N];
        end
        for (int i = 0; i < N; i++) begin
            w_first[i] = w_rot[i] & ~w_found;
            w_found    = w_found | w_rot[i];
        end
        for (int i = 0; i < N; i++) begin
            pick_oh[(i + int'(ptr)) % N] = w_first[i];
        end
    end

    assign pick_id  = IDW'(oh2idx(MAX_N'(pick_oh)));
    assign pick_vld = |req;

endmodule

// File: rtl/rr_lock_arbiter.sv
// Registered round-robin arbiter; grant is locked until the owner releases.
// Define ARB_GRANT_TIMEOUT_EN to force release after TIMEOUT_CYC held cycles.
module rr_lock_arbiter
    import arb_pkg::*;
#(
    parameter  int N           = 4,
    parameter  int TIMEOUT_CYC = 16,
    localparam int IDW         = idw_of(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           rel,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    arb_state_e     r_state;
    logic [N-1:0]   r_gnt;
    logic [IDW-1:0] r_gnt_id;
    logic [IDW-1:0] r_ptr;

    logic           w_own;
    logic           w_force;
    logic           w_release;
    logic [IDW-1:0] w_ptr_nxt;
    logic [IDW-1:0] w_ptr_sel;
    logic [N-1:0]   w_pick_oh;
    logic [IDW-1:0] w_pick_id;
    logic           w_pick_vld;

    assign w_own     = (r_state == ST_OWN);
    assign w_ptr_nxt = (r_gnt_id == IDW'(N - 1)) ? '0
                     : r_gnt_id + IDW'(1);
    assign w_release = w_own & (rel | ~req[r_gnt_id] | w_force);
    // The release edge re-arbitrates with the already-rotated pointer.
    assign w_ptr_sel = w_own ? w_ptr_nxt : r_ptr;

    rr_prio_pick #(
        .N(N)
    ) u_pick (
        .req      (req),
        .ptr      (w_ptr_sel),
        .pick_oh  (w_pick_oh),
        .pick_id  (w_pick_id),
        .pick_vld (w_pick_vld)
    );

`ifdef ARB_GRANT_TIMEOUT_EN
    localparam int CW = cw_of(TIMEOUT_CYC);

    logic [CW-1:0] r_hold;
    logic          r_timeout;

    assign w_force = w_own & ~rel & req[r_gnt_id]
                   & (r_hold == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
            if (w_own && !w_release) begin
                r_hold <= r_hold + CW'(1);
            end else begin
                r_hold <= '0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_state  <= ST_OWN;
                        r_gnt    <= w_pick_oh;
                        r_gnt_id <= w_pick_id;
                    end
                end
                ST_OWN: begin
                    if (w_release) begin
                        r_ptr <= w_ptr_nxt;
                        if (w_pick_vld) begin
                            r_gnt    <= w_pick_oh;
                            r_gnt_id <= w_pick_id;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_gnt    <= '0;
                            r_gnt_id <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign gnt_id = r_gnt_id;
    assign busy   = w_own;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed and random checks of rr_lock_arbiter against a queue-free
// behavioural model of the rotating-priority lock rules.
module tb_rr_lock_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;
`ifdef ARB_GRANT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         rel;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         timeout;

    int n_chk;
    int n_fail;

    int m_ptr;
    int m_own;
    bit m_busy;
    bit m_to;
    int m_hold;

    rr_lock_arbiter #(
        .N           (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mpick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_own  = 0;
        m_busy = 1'b0;
        m_to   = 1'b0;
        m_hold = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic l);
        int p;
        bit forced;
        m_to = 1'b0;
        if (!m_busy) begin
            p = mpick(r, m_ptr);
            if (p >= 0) begin
                m_busy = 1'b1;
                m_own  = p;
                m_hold = 0;
            end
        end else begin
            forced = TO_EN && (m_hold == TO - 1) && !l && r[m_own];
            if (l || !r[m_own] || forced) begin
                m_to  = forced;
                m_ptr = (m_own + 1) % N;
                p     = mpick(r, m_ptr);
                if (p >= 0) begin
                    m_own = p;
                end else begin
                    m_busy = 1'b0;
                    m_own  = 0;
                end
                m_hold = 0;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] eg;
        eg = m_busy ? N'(1 << m_own) : '0;
        chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
        chk({tag, "_id"}, 32'(gnt_id), m_busy ? 32'(m_own) : 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'(m_busy));
        chk({tag, "_to"}, 32'(timeout), 32'(m_to));
    endtask

    task automatic step(input logic [N-1:0] r, input logic l,
                        input string tag);
        req = r;
        rel = l;
        @(posedge clk);
        model_step(r, l);
        #1;
        check_all(tag);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        req    = '0;
        rel    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) step(4'b0000, 1'b0, "idle");

        step(4'b1010, 1'b0, "pick1");
        chk("pick1_gnt_const", 32'(gnt), 32'h2);
        step(4'b1010, 1'b1, "rel_to3");
        chk("rel_to3_gnt_const", 32'(gnt), 32'h8);
        step(4'b0000, 1'b0, "drop_idle");
        step(4'b0000, 1'b1, "rel_idle");
        step(4'b0000, 1'b1, "rel_idle2");

        step(4'b1111, 1'b0, "all0");
        chk("all_first_const", 32'(gnt), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            step(4'b1111, 1'b0, "all_hold");
            step(4'b1111, 1'b1, "all_rot");
            chk("all_rot_const", 32'(gnt), 32'(1 << (k % N)));
        end
        step(4'b0000, 1'b0, "all_drop");

        step(4'b1000, 1'b0, "sole3");
        step(4'b1000, 1'b1, "sole3_rel");
        chk("sole3_regrant_const", 32'(gnt), 32'h8);
        step(4'b1000, 1'b0, "sole3_hold");
        step(4'b0100, 1'b0, "owner_drop");
        chk("owner_drop_const", 32'(gnt), 32'h4);

        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_gnt", 32'(gnt), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0110, 1'b0, "post_rst");
        chk("post_rst_const", 32'(gnt), 32'h2);
        step(4'b0000, 1'b0, "post_rst_drop");

        step(4'b0011, 1'b0, "to_start");
        for (int k = 0; k < 20; k++) step(4'b0011, 1'b0, "to_hold");
`ifdef ARB_GRANT_TIMEOUT_EN
        step(4'b0000, 1'b0, "to_clear");
        step(4'b0011, 1'b0, "to_g0");
        for (int k = 1; k < TO; k++) step(4'b0011, 1'b0, "to_wait");
        step(4'b0011, 1'b0, "to_fire");
        chk("to_fire_gnt_const", 32'(gnt), 32'h2);
        chk("to_fire_pulse_const", 32'(timeout), 32'h1);
        step(4'b0011, 1'b0, "to_after");
        chk("to_after_pulse_const", 32'(timeout), 32'h0);
`endif

        for (int k = 0; k < 400; k++) begin
            step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                 "rand");
        end
        for (int k = 0; k < 60; k++) begin
            step(4'b1111, ($urandom_range(0, 7) == 0), "rand_full");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
